// File: rtl/regfile_seq_pkg.sv
// Shared widths, opcode and state encodings for the register-file operation sequencer.
package regfile_seq_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    EXEC    = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational operation unit; the top bit of sum is ADD carry-out or SUB borrow.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = regfile_seq_pkg::DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   sum
);

  // Zero-extending both operands makes bit DATA_W the borrow when a < b on SUB.
  always_comb begin
    sum = '0;
    case (op)
      OP_ADD:  sum = {1'b0, a} + {1'b0, b};
      OP_SUB:  sum = {1'b0, a} - {1'b0, b};
      OP_MOV:  sum = {1'b0, a};
      OP_XOR:  sum = {1'b0, a ^ b};
      default: sum = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Accepts one command, reads two registers, computes, and writes the result back
// through the register file's mode/address/data interface.
module regfile_op_sequencer #(
  parameter int DATA_W    = regfile_seq_pkg::DATA_W,
  parameter int ADDR_W    = regfile_seq_pkg::ADDR_W,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_value,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_value1,
  input  logic [DATA_W-1:0] rf_read_value2,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  import regfile_seq_pkg::*;

  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT - 1);

  state_e            state;
  logic [2:0]        wait_cnt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   alu_sum;

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (opa),
    .b   (opb),
    .sum (alu_sum)
  );

  // Read addresses double as the latched source registers; they stay put once the read is over.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      wait_cnt       <= '0;
      op_q           <= '0;
      dst_q          <= '0;
      opa            <= '0;
      opb            <= '0;
      rf_mode        <= 1'b0;
      rf_write_addr  <= '0;
      rf_write_value <= '0;
      rf_read_addr1  <= '0;
      rf_read_addr2  <= '0;
      done           <= 1'b0;
      result         <= '0;
      carry          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q          <= cmd_op;
            dst_q         <= cmd_dst;
            rf_read_addr1 <= cmd_src1;
            rf_read_addr2 <= cmd_src2;
            wait_cnt      <= '0;
            cmd_ready     <= 1'b0;
            state         <= READ;
          end
        end
        READ: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        CAPTURE: begin
          opa   <= rf_read_value1;
          opb   <= rf_read_value2;
          state <= EXEC;
        end
        EXEC: begin
          result         <= alu_sum[DATA_W-1:0];
          carry          <= alu_sum[DATA_W];
          rf_write_value <= alu_sum[DATA_W-1:0];
          rf_write_addr  <= dst_q;
          rf_mode        <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          rf_mode <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          rf_mode   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench: behavioural register file model around two sequencers (READ_WAIT 1 and 3).
module tb_regfile_op_sequencer;

  typedef struct {
    int dst;
    int val;
    bit c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_valid3;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_src1, cmd_src2, cmd_dst;

  logic        cmd_ready, rf_mode, done, carry;
  logic [4:0]  rf_write_addr, rf_read_addr1, rf_read_addr2;
  logic [15:0] rf_write_value, rf_read_value1, rf_read_value2, result;

  logic        cmd_ready3, rf_mode3, done3, carry3;
  logic [4:0]  rf_write_addr3, rf_read_addr13, rf_read_addr23;
  logic [15:0] rf_write_value3, rf_read_value13, rf_read_value23, result3;

  logic [15:0] rf [32];
  logic [15:0] rf3 [32];
  int          model [32];
  exp_t        sb [$];
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) if (rf_mode) rf[rf_write_addr] <= rf_write_value;
  always @(posedge clk) if (rf_mode3) rf3[rf_write_addr3] <= rf_write_value3;
  assign rf_read_value1  = rf[rf_read_addr1];
  assign rf_read_value2  = rf[rf_read_addr2];
  assign rf_read_value13 = rf3[rf_read_addr13];
  assign rf_read_value23 = rf3[rf_read_addr23];

  regfile_op_sequencer #(.DATA_W(16), .ADDR_W(5), .READ_WAIT(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .rf_mode(rf_mode), .rf_write_addr(rf_write_addr), .rf_write_value(rf_write_value),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_value1(rf_read_value1), .rf_read_value2(rf_read_value2),
    .done(done), .result(result), .carry(carry)
  );

  regfile_op_sequencer #(.DATA_W(16), .ADDR_W(5), .READ_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .rf_mode(rf_mode3), .rf_write_addr(rf_write_addr3), .rf_write_value(rf_write_value3),
    .rf_read_addr1(rf_read_addr13), .rf_read_addr2(rf_read_addr23),
    .rf_read_value1(rf_read_value13), .rf_read_value2(rf_read_value23),
    .done(done3), .result(result3), .carry(carry3)
  );

  function automatic void ref_op(input logic [1:0] op, input int a, input int b,
                                 output int r, output bit c);
    case (op)
      2'b00: begin r = a + b; c = (r > 65535); r = r % 65536; end
      2'b01: begin c = (a < b); r = (a - b + 65536) % 65536; end
      2'b10: begin r = a; c = 1'b0; end
      default: begin r = a ^ b; c = 1'b0; end
    endcase
  endfunction

  task automatic preload(input int idx, input int val);
    rf[idx]    = 16'(val);
    rf3[idx]   = 16'(val);
    model[idx] = val;
  endtask

  // Returns at #1 after the accepting edge; the expected write is queued at that point.
  task automatic send(input logic [1:0] op, input int s1, input int s2, input int d,
                      input bit hold, output int hs);
    exp_t e;
    int   guard = 0;
    cmd_op = op; cmd_src1 = 5'(s1); cmd_src2 = 5'(s2); cmd_dst = 5'(d);
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("[TB] FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    hs = cycle;
    if (!hold) cmd_valid = 1'b0;
    e.dst = d;
    ref_op(op, model[s1], model[s2], e.val, e.c);
    model[d] = e.val;
    sb.push_back(e);
  endtask

  task automatic complete(input int rf_j, input int done_j);
    exp_t e;
    int first_rf = -1, n_rf = 0, first_done = -1, n_done = 0;
    for (int j = 0; j < 30; j++) begin
      if (j == 0) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL busy_ready: cmd_ready=%b required 0", cmd_ready);
        end
      end
      if (rf_mode === 1'b1) begin
        n_rf++;
        if (first_rf < 0) first_rf = j;
        if (sb.size() > 0) begin
          checks++;
          if (rf_write_addr !== 5'(sb[0].dst) || rf_write_value !== 16'(sb[0].val)) begin
            errors++;
            $display("[TB] FAIL write_port: addr=%0d value=%h required addr=%0d value=%h",
                     rf_write_addr, rf_write_value, sb[0].dst, 16'(sb[0].val));
          end
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0 && sb.size() > 0) begin
          first_done = j;
          e = sb.pop_front();
          checks++;
          if (result !== 16'(e.val) || carry !== e.c) begin
            errors++;
            $display("[TB] FAIL result: result=%h carry=%b required result=%h carry=%b",
                     result, carry, 16'(e.val), e.c);
          end
        end
      end
      if (first_done >= 0 && j == first_done + 1) begin
        checks++;
        if (cmd_ready !== 1'b1 || n_done != 1) begin
          errors++;
          $display("[TB] FAIL ready_return: cmd_ready=%b done_cycles=%0d required 1 and 1",
                   cmd_ready, n_done);
        end
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (first_done != done_j || first_rf != rf_j || n_rf != 1) begin
      errors++;
      $display("[TB] FAIL latency: done_at=%0d write_at=%0d write_cycles=%0d required %0d %0d 1",
               first_done, first_rf, n_rf, done_j, rf_j);
    end
  endtask

  task automatic check_rf(input string name, input int idx, input int val);
    checks++;
    if (rf[idx] !== 16'(val)) begin
      errors++;
      $display("[TB] FAIL %s: R%0d=%h required %h", name, idx, rf[idx], 16'(val));
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    cmd_op = 2'b00; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rf_mode !== 1'b0 || done !== 1'b0 || carry !== 1'b0 ||
        result !== 16'h0 || rf_write_addr !== 5'h0 || rf_write_value !== 16'h0 ||
        rf_read_addr1 !== 5'h0 || rf_read_addr2 !== 5'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b mode=%b done=%b carry=%b result=%h wa=%h wv=%h ra1=%h ra2=%h required 1 0 0 0 0 0 0 0 0",
               cmd_ready, rf_mode, done, carry, result, rf_write_addr, rf_write_value,
               rf_read_addr1, rf_read_addr2);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int hs;
    send(2'b00, 0, 1, 2, 1'b0, hs);
    complete(3, 4);
    check_rf("add_r2", 2, 16'h2495);
  endtask

  task automatic test_add_carry;
    int hs;
    preload(3, 16'hA06B);
    preload(4, 16'h6000);
    send(2'b00, 3, 4, 5, 1'b0, hs);
    complete(3, 4);
    check_rf("add_carry_r5", 5, 16'h006B);
  endtask

  task automatic test_sub_then_mov;
    int hs;
    send(2'b01, 0, 1, 0, 1'b0, hs);
    complete(3, 4);
    check_rf("sub_r0", 0, 16'hFFCF);
    send(2'b10, 0, 0, 6, 1'b0, hs);
    complete(3, 4);
    check_rf("mov_r6", 6, 16'hFFCF);
    send(2'b01, 2, 2, 9, 1'b0, hs);
    complete(3, 4);
    check_rf("sub_same_r9", 9, 0);
  endtask

  task automatic test_back_to_back;
    int hs1, hs2;
    send(2'b11, 1, 1, 1, 1'b1, hs1);
    cmd_op = 2'b10; cmd_src1 = 5'd3; cmd_src2 = 5'd0; cmd_dst = 5'd8;
    complete(3, 4);
    send(2'b10, 3, 0, 8, 1'b0, hs2);
    checks++;
    if (hs2 - hs1 != 6 || rf_read_addr1 !== 5'd3) begin
      errors++;
      $display("[TB] FAIL back_to_back_accept: gap=%0d ra1=%0d required 6 3", hs2 - hs1, rf_read_addr1);
    end
    complete(3, 4);
    check_rf("xor_r1", 1, 0);
    check_rf("mov_r8", 8, 16'hA06B);
  endtask

  task automatic test_reset_abort;
    bit saw_write = 0, saw_done = 0;
    preload(7, 16'h5555);
    cmd_op = 2'b00; cmd_src1 = 5'd3; cmd_src2 = 5'd4; cmd_dst = 5'd7;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || rf_read_addr1 !== 5'd3) begin
      errors++; $display("[TB] FAIL abort_accept: ready=%b ra1=%0d required 0 3", cmd_ready, rf_read_addr1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rf_mode !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_idle: ready=%b mode=%b required 1 0", cmd_ready, rf_mode);
    end
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (rf_mode === 1'b1) saw_write = 1;
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_write || saw_done || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_quiet: write=%b done=%b ready=%b required 0 0 1", saw_write, saw_done, cmd_ready);
    end
    check_rf("abort_r7", 7, 16'h5555);
  endtask

  task automatic test_read_wait3;
    int first_rf = -1, n_rf = 0, first_done = -1;
    logic [15:0] res = '0;
    logic        c = 1'b0;
    cmd_op = 2'b00; cmd_src1 = 5'd10; cmd_src2 = 5'd11; cmd_dst = 5'd12;
    rf3[10] = 16'h1232; rf3[11] = 16'h1263; rf3[12] = 16'h0;
    checks++;
    if (cmd_ready3 !== 1'b1) begin
      errors++; $display("[TB] FAIL rw3_ready: cmd_ready=%b required 1", cmd_ready3);
    end
    cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (rf_mode3 === 1'b1) begin
        n_rf++;
        if (first_rf < 0) first_rf = j;
      end
      if (done3 === 1'b1 && first_done < 0) begin
        first_done = j; res = result3; c = carry3;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (first_done != 6 || first_rf != 5 || n_rf != 1) begin
      errors++;
      $display("[TB] FAIL rw3_latency: done_at=%0d write_at=%0d write_cycles=%0d required 6 5 1",
               first_done, first_rf, n_rf);
    end
    checks++;
    if (res !== 16'h2495 || c !== 1'b0 || rf3[12] !== 16'h2495) begin
      errors++;
      $display("[TB] FAIL rw3_result: result=%h carry=%b R12=%h required 2495 0 2495", res, c, rf3[12]);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) preload(i, 0);
    test_reset;
    preload(0, 16'h1232);
    preload(1, 16'h1263);
    test_add;
    test_add_carry;
    test_sub_then_mov;
    test_back_to_back;
    test_reset_abort;
    test_read_wait3;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: %0d left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
